// File: rtl/sprite_compositor_if.sv
// Pixel-in, sprite ROM and composited-pixel-out signals of the sprite compositor.
// The slave modport is the compositor's view and the master modport is the surrounding pipeline's view.
interface sprite_compositor_if #(
  parameter int N_ENEMY = 4
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [8:0]            PixelX;
  logic [8:0]            PixelY;
  logic                  player_is_obj;
  logic [12:0]           player_address;
  logic [N_ENEMY-1:0]    enemy_is_obj;
  logic [13*N_ENEMY-1:0] enemy_address;
  logic [13:0]           rom_addr;
  logic [3:0]            rom_data;
  logic                  out_valid;
  logic [8:0]            out_x;
  logic [8:0]            out_y;
  logic [3:0]            out_color;
  logic [3:0]            out_layer;

  modport slave (
    input  pix_valid, PixelX, PixelY, player_is_obj, player_address,
           enemy_is_obj, enemy_address, rom_data,
    output pix_ready, rom_addr, out_valid, out_x, out_y, out_color, out_layer
  );

  modport master (
    output pix_valid, PixelX, PixelY, player_is_obj, player_address,
           enemy_is_obj, enemy_address, rom_data,
    input  pix_ready, rom_addr, out_valid, out_x, out_y, out_color, out_layer
  );
endinterface

// File: rtl/sprite_compositor.sv
// Per-pixel sprite priority resolver: reads ROM in priority order (player, enemy 0..N-1) until an opaque texel is found.
// Latency is k*(ROM_LATENCY+1)+1 cycles for k reads; pix_ready is high only in IDLE, so upstream holds pix_valid meanwhile.
module sprite_compositor #(
  parameter int          N_ENEMY     = 4,
  parameter int          ROM_LATENCY = 1,
  parameter int          MAX_TRIES   = 3,
  parameter logic [3:0]  BG_COLOR    = 4'd1
) (
  input logic               Clk,
  input logic               Reset,
  sprite_compositor_if.slave bus
);
  localparam int N  = N_ENEMY + 1;
  localparam int IW = $clog2(N);
  localparam logic [1:0] LAT   = 2'(ROM_LATENCY);
  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  mask_q;
  logic [12:0]   addr_q [N];
  logic [8:0]    x_q;
  logic [8:0]    y_q;
  logic [3:0]    tries;
  logic [3:0]    cur_layer;
  logic [1:0]    wait_cnt;

  logic [N-1:0]  cand_mask;
  logic [N-1:0]  next_mask;
  logic [12:0]   cand_addr [N];
  logic [IW-1:0] sel_idx;
  logic          sel_any;

  // In IDLE the candidates come straight from the inputs so the first read launches on the accept edge.
  always_comb begin
    cand_mask = mask_q;
    sel_idx   = '0;
    sel_any   = 1'b0;
    for (int i = 0; i < N; i++) cand_addr[i] = addr_q[i];
    if (state == IDLE) begin
      cand_mask    = {bus.enemy_is_obj, bus.player_is_obj};
      cand_addr[0] = bus.player_address;
      for (int k = 0; k < N_ENEMY; k++) cand_addr[k+1] = bus.enemy_address[13*k +: 13];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_mask[i]) begin
        sel_idx = IW'(i);
        sel_any = 1'b1;
      end
    end
    next_mask = cand_mask & ~(N'(1) << sel_idx);
  end

  assign bus.pix_ready = (state == IDLE) && !Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      mask_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      tries         <= '0;
      cur_layer     <= '0;
      wait_cnt      <= '0;
      bus.rom_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_color <= '0;
      bus.out_layer <= '0;
      for (int i = 0; i < N; i++) addr_q[i] <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pix_valid) begin
            x_q <= bus.PixelX;
            y_q <= bus.PixelY;
            for (int i = 0; i < N; i++) addr_q[i] <= cand_addr[i];
            if (!sel_any) begin
              state         <= DONE;
              mask_q        <= '0;
              tries         <= '0;
              bus.out_valid <= 1'b1;
              bus.out_color <= BG_COLOR;
              bus.out_layer <= 4'd0;
              bus.out_x     <= bus.PixelX;
              bus.out_y     <= bus.PixelY;
            end else begin
              state        <= WAIT;
              bus.rom_addr <= {(sel_idx != '0), cand_addr[sel_idx]};
              mask_q       <= next_mask;
              wait_cnt     <= LAT;
              tries        <= 4'd1;
              cur_layer    <= 4'(sel_idx) + 4'd1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (bus.rom_data != 4'd0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_color <= bus.rom_data;
            bus.out_layer <= cur_layer;
            bus.out_x     <= x_q;
            bus.out_y     <= y_q;
          end else if (sel_any && (tries < MAX_T)) begin
            bus.rom_addr <= {(sel_idx != '0), cand_addr[sel_idx]};
            mask_q       <= next_mask;
            wait_cnt     <= LAT;
            tries        <= tries + 4'd1;
            cur_layer    <= 4'(sel_idx) + 4'd1;
          end else begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_color <= BG_COLOR;
            bus.out_layer <= 4'd0;
            bus.out_x     <= x_q;
            bus.out_y     <= y_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
